// File: rtl/ahb_lite_apb_bridge.sv
// AHB-Lite slave to APB4 master bridge: one AHB transfer becomes one APB SETUP/ACCESS pair.
// Latency: read completes in cycle 3, write in cycle 4 (cycle 0 = address phase, PREADY=1), plus APB wait states.
// Backpressure: HREADYOUT is held low while the APB transfer runs; PSLVERR becomes a two-cycle AHB ERROR.
module ahb_lite_apb_bridge #(
    parameter int PADDR_W = 16
) (
    input  logic               HCLK,
    input  logic               HRESET,
    input  logic               HSEL,
    input  logic [31:0]        HADDR,
    input  logic [1:0]         HTRANS,
    input  logic [2:0]         HSIZE,
    input  logic [3:0]         HPROT,
    input  logic               HWRITE,
    input  logic [31:0]        HWDATA,
    input  logic               HREADY,
    output logic               HREADYOUT,
    output logic               HRESP,
    output logic [31:0]        HRDATA,
    output logic               PSEL,
    output logic               PENABLE,
    output logic               PWRITE,
    output logic [PADDR_W-1:0] PADDR,
    output logic [31:0]        PWDATA,
    output logic [3:0]         PSTRB,
    output logic [2:0]         PPROT,
    input  logic [31:0]        PRDATA,
    input  logic               PREADY,
    input  logic               PSLVERR
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WWAIT  = 3'd1,
        SETUP  = 3'd2,
        ACCESS = 3'd3,
        DONE   = 3'd4,
        ERR1   = 3'd5,
        ERR2   = 3'd6
    } state_t;

    state_t     state;
    logic       acc;
    logic [3:0] strb;

    // Bits that the bridge deliberately ignores (upper address, HTRANS[0], HPROT[3:2]).
    logic unused_bits;
    assign unused_bits = ^{HADDR[31:PADDR_W], HTRANS[0], HPROT[3:2]};

    // A real transfer is presented to the bridge only when the bus-level ready qualifies it.
    assign acc = HSEL & HTRANS[1] & HREADY;

    // Byte strobes derived from size and low address bits; reads never assert strobes.
    always_comb begin
        strb = 4'b0000;
        if (HWRITE) begin
            case (HSIZE)
                3'd0:    strb = 4'b0001 << HADDR[1:0];
                3'd1:    strb = 4'b0011 << {HADDR[1], 1'b0};
                default: strb = 4'b1111;
            endcase
        end
    end

    // Bridge FSM; every output is registered and set for the state being entered.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state     <= IDLE;
            HREADYOUT <= 1'b1;
            HRESP     <= 1'b0;
            HRDATA    <= '0;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
            PSTRB     <= '0;
            PPROT     <= '0;
        end else begin
            case (state)
                // IDLE, DONE and ERR2 all take the next address phase with the same rules.
                IDLE, DONE, ERR2: begin
                    HREADYOUT <= 1'b1;
                    HRESP     <= 1'b0;
                    PSEL      <= 1'b0;
                    PENABLE   <= 1'b0;
                    if (acc) begin
                        PADDR  <= HADDR[PADDR_W-1:0];
                        PWRITE <= HWRITE;
                        PSTRB  <= strb;
                        PPROT  <= {~HPROT[0], 1'b0, HPROT[1]};
                        if (HSIZE > 3'd2) begin
                            // Oversized transfer: error out without touching APB.
                            state     <= ERR1;
                            HREADYOUT <= 1'b0;
                            HRESP     <= 1'b1;
                        end else if (HWRITE) begin
                            // Write data arrives one cycle later, in the data phase.
                            state     <= WWAIT;
                            HREADYOUT <= 1'b0;
                        end else begin
                            state     <= SETUP;
                            HREADYOUT <= 1'b0;
                            PSEL      <= 1'b1;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                WWAIT: begin
                    PWDATA <= HWDATA;
                    PSEL   <= 1'b1;
                    state  <= SETUP;
                end
                SETUP: begin
                    PENABLE <= 1'b1;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    // Everything on APB stays frozen until the peripheral answers.
                    if (PREADY) begin
                        PSEL    <= 1'b0;
                        PENABLE <= 1'b0;
                        if (PSLVERR) begin
                            state <= ERR1;
                            HRESP <= 1'b1;
                        end else begin
                            state     <= DONE;
                            HREADYOUT <= 1'b1;
                            if (!PWRITE) begin
                                HRDATA <= PRDATA;
                            end
                        end
                    end
                end
                ERR1: begin
                    // Second cycle of the AHB ERROR response.
                    state     <= ERR2;
                    HREADYOUT <= 1'b1;
                    HRESP     <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    HREADYOUT <= 1'b1;
                    HRESP     <= 1'b0;
                    PSEL      <= 1'b0;
                    PENABLE   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_lite_apb_bridge.sv
// Bench for the AHB-Lite to APB4 bridge: table of single transfers plus hand sequences.
// Inputs driven 1ns after the rising edge, outputs sampled on the falling edge.
// The APB slave model inserts a programmable number of wait states.
module tb_ahb_lite_apb_bridge;

    logic        HCLK;
    logic        HRESET;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic [3:0]  HPROT;
    logic        HWRITE;
    logic [31:0] HWDATA;
    wire         HREADY;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] HRDATA;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [15:0] PADDR;
    logic [31:0] PWDATA;
    logic [3:0]  PSTRB;
    logic [2:0]  PPROT;
    wire  [31:0] PRDATA;
    wire         PREADY;
    wire         PSLVERR;

    int          errors = 0;
    int          checks = 0;

    // APB slave model state
    int          wait_n = 0;
    int          acc_cnt = 0;
    logic        slverr_en = 1'b0;
    logic [31:0] rd_val = '0;

    assign HREADY  = HREADYOUT;
    assign PREADY  = PSEL && PENABLE && (acc_cnt >= wait_n);
    assign PSLVERR = slverr_en && PREADY;
    assign PRDATA  = rd_val;

    ahb_lite_apb_bridge #(.PADDR_W(16)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HSIZE(HSIZE), .HPROT(HPROT), .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY),
        .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB), .PPROT(PPROT),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    // Count completed ACCESS cycles to time PREADY.
    always @(posedge HCLK) begin
        if (PSEL && PENABLE) acc_cnt <= acc_cnt + 1;
        else                 acc_cnt <= 0;
    end

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [3:0]  prot;
        logic [31:0] wdata;
        logic [31:0] prdata;
        int          wait_n;
        logic        slverr;
        int          exp_done;
        logic        exp_hresp;
        logic [31:0] exp_hrdata;
        int          exp_psel;
        logic [15:0] exp_paddr;
        logic [3:0]  exp_pstrb;
        logic [2:0]  exp_pprot;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge HCLK);
        #1;
    endtask

    task automatic idle_bus();
        HSEL   = 1'b0;
        HTRANS = 2'b00;
    endtask

    // One isolated transfer: address phase, then idle bus until HREADYOUT returns.
    task automatic run_vec(input vec_t v, input string tag);
        int          done;
        int          psel_cnt;
        logic        stable_bad;
        logic        pen_bad;
        logic        prev_resp;
        logic        done_resp;
        logic [31:0] done_rdata;
        logic [15:0] c_paddr;
        logic [3:0]  c_pstrb;
        logic [2:0]  c_pprot;
        logic        c_pwrite;
        logic [31:0] c_pwdata;
        cyc();
        wait_n    = v.wait_n;
        slverr_en = v.slverr;
        rd_val    = v.prdata;
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = v.addr; HWRITE = v.write;
        HSIZE = v.size; HPROT = v.prot;
        cyc();
        idle_bus();
        HWDATA = v.wdata;
        done = 0; psel_cnt = 0; stable_bad = 1'b0; pen_bad = 1'b0;
        prev_resp = 1'b0; done_resp = 1'b0; done_rdata = '0;
        c_paddr = '0; c_pstrb = '0; c_pprot = '0; c_pwrite = 1'b0; c_pwdata = '0;
        for (int c = 1; c <= 40 && done == 0; c++) begin
            @(negedge HCLK);
            if (PENABLE && !PSEL) pen_bad = 1'b1;
            if (PSEL) begin
                if (psel_cnt == 0) begin
                    c_paddr = PADDR; c_pstrb = PSTRB; c_pprot = PPROT;
                    c_pwrite = PWRITE; c_pwdata = PWDATA;
                end else if (PADDR !== c_paddr || PSTRB !== c_pstrb || PPROT !== c_pprot ||
                             PWRITE !== c_pwrite || PWDATA !== c_pwdata) begin
                    stable_bad = 1'b1;
                end
                psel_cnt++;
            end
            if (HREADYOUT) begin
                done       = c;
                done_resp  = HRESP;
                done_rdata = HRDATA;
            end else begin
                prev_resp = HRESP;
            end
        end
        chk({tag, " done_cycle"}, done, v.exp_done);
        chk({tag, " hresp_done"}, done_resp, v.exp_hresp);
        chk({tag, " hresp_wait"}, prev_resp, v.exp_hresp);
        chk({tag, " hrdata"}, done_rdata, v.exp_hrdata);
        chk({tag, " psel_cycles"}, psel_cnt, v.exp_psel);
        chk({tag, " penable_wo_psel"}, pen_bad, 0);
        if (psel_cnt > 0) begin
            chk({tag, " paddr"}, c_paddr, v.exp_paddr);
            chk({tag, " pstrb"}, c_pstrb, v.exp_pstrb);
            chk({tag, " pprot"}, c_pprot, v.exp_pprot);
            chk({tag, " pwrite"}, c_pwrite, v.write);
            chk({tag, " apb_stable"}, stable_bad, 0);
            if (v.write) chk({tag, " pwdata"}, c_pwdata, v.wdata);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t rv;
        //          wr    addr           sz    prot     wdata         prdata        w  err done hresp hrdata      psel paddr    pstrb    pprot
        vecs[0] = '{1'b0, 32'h4000_0010, 3'd2, 4'b0011, 32'h0,        32'hCAFE_F00D, 0, 1'b0, 3, 1'b0, 32'hCAFE_F00D, 2, 16'h0010, 4'b0000, 3'b001};
        vecs[1] = '{1'b1, 32'h4000_0003, 3'd0, 4'b0000, 32'hAB00_0000, 32'h0,        0, 1'b0, 4, 1'b0, 32'hCAFE_F00D, 2, 16'h0003, 4'b1000, 3'b100};
        vecs[2] = '{1'b0, 32'h4000_1236, 3'd1, 4'b0010, 32'h0,        32'h1234_5678, 3, 1'b0, 6, 1'b0, 32'h1234_5678, 5, 16'h1236, 4'b0000, 3'b101};
        vecs[3] = '{1'b1, 32'h4000_0102, 3'd1, 4'b0001, 32'h5555_AAAA, 32'h0,        0, 1'b1, 5, 1'b1, 32'h1234_5678, 2, 16'h0102, 4'b1100, 3'b000};
        vecs[4] = '{1'b0, 32'h4000_0020, 3'd3, 4'b0001, 32'h0,        32'hFFFF_FFFF, 0, 1'b0, 2, 1'b1, 32'h1234_5678, 0, 16'h0020, 4'b0000, 3'b000};
        vecs[5] = '{1'b1, 32'h4000_FFFC, 3'd2, 4'b0011, 32'hDEAD_BEEF, 32'h0,        1, 1'b0, 5, 1'b0, 32'h1234_5678, 3, 16'hFFFC, 4'b1111, 3'b001};
        vecs[6] = '{1'b0, 32'h4000_0005, 3'd0, 4'b0000, 32'h0,        32'h9999_9999, 0, 1'b1, 4, 1'b1, 32'h1234_5678, 2, 16'h0005, 4'b0000, 3'b100};

        HRESET = 1'b1;
        HSEL = 1'b0; HADDR = '0; HTRANS = 2'b00; HSIZE = 3'd0; HPROT = 4'b0000;
        HWRITE = 1'b0; HWDATA = '0;

        // Reset values
        #12;
        chk("rst hreadyout", HREADYOUT, 1);
        chk("rst hresp", HRESP, 0);
        chk("rst psel", PSEL, 0);
        chk("rst penable", PENABLE, 0);
        chk("rst pwrite", PWRITE, 0);
        chk("rst hrdata", HRDATA, 0);
        chk("rst paddr", PADDR, 0);
        chk("rst pwdata", PWDATA, 0);
        chk("rst pstrb", PSTRB, 0);
        chk("rst pprot", PPROT, 0);
        #10;
        HRESET = 1'b0;

        // Table of isolated transfers
        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // IDLE and BUSY with HSEL give a zero-wait OKAY and no APB activity
        cyc();
        HSEL = 1'b1; HTRANS = 2'b00; HADDR = 32'h4000_0100; HWRITE = 1'b0; HSIZE = 3'd2;
        cyc();
        HTRANS = 2'b01;
        @(negedge HCLK);
        chk("idle_trans hreadyout", HREADYOUT, 1);
        chk("idle_trans psel", PSEL, 0);
        cyc();
        idle_bus();
        @(negedge HCLK);
        chk("busy_trans hreadyout", HREADYOUT, 1);
        chk("busy_trans hresp", HRESP, 0);
        chk("busy_trans psel", PSEL, 0);

        // Write with PSLVERR, then a NONSEQ read accepted during ERR2
        cyc();
        wait_n = 0; slverr_en = 1'b1;
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h4000_0040; HWRITE = 1'b1; HSIZE = 3'd2; HPROT = 4'b0011;
        cyc();
        idle_bus();
        HWDATA = 32'h1111_2222;
        begin
            int seen;
            seen = 0;
            for (int c = 0; c < 20 && seen == 0; c++) begin
                @(negedge HCLK);
                if (!HREADYOUT && HRESP) seen = 1;
            end
            chk("err2seq err1_seen", seen, 1);
        end
        slverr_en = 1'b0;
        rd_val = 32'h600D_F00D;
        cyc();
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h4000_0044; HWRITE = 1'b0; HSIZE = 3'd2;
        @(negedge HCLK);
        chk("err2seq err2 hreadyout", HREADYOUT, 1);
        chk("err2seq err2 hresp", HRESP, 1);
        cyc();
        idle_bus();
        @(negedge HCLK);
        chk("err2seq setup psel", PSEL, 1);
        chk("err2seq setup penable", PENABLE, 0);
        chk("err2seq setup paddr", PADDR, 16'h0044);
        chk("err2seq setup hresp", HRESP, 0);
        @(negedge HCLK);
        chk("err2seq access penable", PENABLE, 1);
        @(negedge HCLK);
        chk("err2seq done hreadyout", HREADYOUT, 1);
        chk("err2seq done hresp", HRESP, 0);
        chk("err2seq done hrdata", HRDATA, 32'h600D_F00D);

        // Back-to-back read then write, the write accepted in DONE
        cyc();
        wait_n = 0; rd_val = 32'hA5A5_5A5A;
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h4000_0080; HWRITE = 1'b0; HSIZE = 3'd2;
        cyc();
        HADDR = 32'h4000_0084; HWRITE = 1'b1;
        @(negedge HCLK);
        chk("b2b read setup psel", PSEL, 1);
        chk("b2b read setup pwrite", PWRITE, 0);
        cyc();
        cyc();
        @(negedge HCLK);
        chk("b2b read done hreadyout", HREADYOUT, 1);
        chk("b2b read done hrdata", HRDATA, 32'hA5A5_5A5A);
        cyc();
        idle_bus();
        HWDATA = 32'h0F0F_1234;
        @(negedge HCLK);
        chk("b2b wwait hreadyout", HREADYOUT, 0);
        chk("b2b wwait psel", PSEL, 0);
        @(negedge HCLK);
        chk("b2b write setup psel", PSEL, 1);
        chk("b2b write pwrite", PWRITE, 1);
        chk("b2b write paddr", PADDR, 16'h0084);
        chk("b2b write pwdata", PWDATA, 32'h0F0F_1234);
        chk("b2b write pstrb", PSTRB, 4'b1111);
        @(negedge HCLK);
        chk("b2b write access penable", PENABLE, 1);
        @(negedge HCLK);
        chk("b2b write done hreadyout", HREADYOUT, 1);
        chk("b2b write done hresp", HRESP, 0);

        // Reset pulsed during a stalled ACCESS, then a clean read
        cyc();
        wait_n = 10; rd_val = 32'h5A5A_0000;
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h4000_0200; HWRITE = 1'b0; HSIZE = 3'd2;
        cyc();
        idle_bus();
        @(negedge HCLK);
        @(negedge HCLK);
        chk("rstmid access penable", PENABLE, 1);
        #2;
        HRESET = 1'b1;
        #1;
        chk("rstmid psel", PSEL, 0);
        chk("rstmid penable", PENABLE, 0);
        chk("rstmid hreadyout", HREADYOUT, 1);
        chk("rstmid hrdata", HRDATA, 0);
        @(posedge HCLK);
        #2;
        HRESET = 1'b0;
        rv = '{1'b0, 32'h4000_0300, 3'd2, 4'b0010, 32'h0, 32'h7777_8888, 0, 1'b0, 3, 1'b0, 32'h7777_8888, 2, 16'h0300, 4'b0000, 3'b101};
        run_vec(rv, "after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
